color_scheduler: RTL and testbench
==================================

COLOR_SCHEDULER -- requirements
Module: color_scheduler

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000: consecutive stable cycles a synchronised button must hold before its debounced level changes (10 ms at 50 MHz).
REQ-002 Parameter AUTO_FRAMES, default 60: frames between automatic advances in auto mode; legal range 1..65535.
REQ-003 Parameter AUTO_DEFAULT, default 0: value of auto_on after reset.
REQ-004 CLK50MHZ  in  1  single clock domain; all state updates on its rising edge.
REQ-005 RST  in  1  reset, synchronous, active-high.
REQ-006 btn_next  in  1  raw asynchronous push-button: request next colour.
REQ-007 btn_prev  in  1  raw asynchronous push-button: request previous colour.
REQ-008 btn_auto  in  1  raw asynchronous push-button: toggle auto mode.
REQ-009 frame_tick  in  1  one-cycle pulse per video frame, synchronous to CLK50MHZ, asserted during vertical blanking.
REQ-010 next  out  1  one-cycle step-forward pulse to the colour controller.
REQ-011 prev  out  1  one-cycle step-back pulse to the colour controller.
REQ-012 auto_on  out  1  auto mode active.
REQ-013 pending  out  1  high while a request is latched and not yet issued.

Function
REQ-014 Each button SHALL pass through a 2-flop synchroniser, then an independent debouncer whose counter clears whenever the synchronised level equals the debounced level.
REQ-015 A debounced level SHALL change only after the synchronised level differs from it for DEBOUNCE_CYCLES consecutive cycles; a press event is a single cycle on a debounced 0->1 transition; releases generate no event.
REQ-016 A btn_auto press event SHALL toggle auto_on in the following cycle and clear the frame counter.
REQ-017 A btn_next or btn_prev press event SHALL set pend_next or pend_prev respectively; repeated presses before issue SHALL NOT accumulate (one step maximum per frame per direction).
REQ-018 While auto_on=1, the 16-bit frame counter SHALL increment on each frame_tick, wrap from AUTO_FRAMES-1 to 0, and assert auto_due on that wrapping tick; while auto_on=0 it SHALL hold at 0.
REQ-019 Any next/prev press event while auto_on=1 SHALL clear the frame counter, restarting the automatic interval.
REQ-020 FSM states: IDLE (nothing latched), ARMED (pend_next or pend_prev set), ISSUE (output cycle).
REQ-021 IDLE->ARMED on a press event; IDLE->ISSUE on frame_tick with auto_due; otherwise hold.
REQ-022 ARMED->ISSUE on frame_tick; both pend flags SHALL clear on that edge.
REQ-023 Decision at frame_tick: want_next = pend_next OR auto_due, want_prev = pend_prev; exactly one set -> that output is asserted in ISSUE; both set -> they cancel, ISSUE is entered with both outputs 0.
REQ-024 next/prev SHALL be registered, high only during ISSUE, i.e. exactly one cycle, starting the cycle after the deciding frame_tick; next and prev SHALL never be high together.
REQ-025 A press event coinciding with the deciding frame_tick, or occurring during ISSUE, SHALL be latched for the following frame; ISSUE then exits to ARMED, else to IDLE.
REQ-026 pending SHALL equal pend_next OR pend_prev.
REQ-027 A frame_tick arriving in the ISSUE cycle SHALL be ignored for issue purposes but SHALL still advance the frame counter.

Reset
REQ-028 With RST=1 at a clock edge: FSM->IDLE; next=0, prev=0, pending=0; pend flags, frame counter, debounce counters, debounced levels and synchronisers cleared; auto_on=AUTO_DEFAULT.
REQ-029 RST SHALL take priority over every other event, including mid-ISSUE (pulse truncated to zero cycles after the reset edge) and mid-debounce (count discarded).
REQ-030 No press event SHALL be produced by a button already held during reset until it is released and pressed again.

Verification (DEBOUNCE_CYCLES=4, AUTO_FRAMES=3)
REQ-031 btn_next high 10 cycles, frame_tick 20 cycles later -> pending=1 from event to tick; next=1 for exactly one cycle, the cycle after frame_tick; prev=0 throughout.
REQ-032 btn_next glitch high 3 cycles -> no event, pending stays 0, no output on subsequent frame_tick.
REQ-033 btn_next and btn_prev pressed in same frame, then frame_tick -> ISSUE entered, next=0 and prev=0, pending returns to 0.
REQ-034 Press btn_auto, then 7 frame_ticks -> next pulses after ticks 3 and 6 only; btn_prev press after tick 4 -> prev after tick 5, next after tick 7, counter restarted.
REQ-035 btn_prev event same cycle as frame_tick -> no output that frame; prev pulse one cycle after next frame_tick.
REQ-036 RST asserted in ISSUE cycle with next=1 -> next=0, pending=0, auto_on=AUTO_DEFAULT after the reset edge; held button produces no event until released and re-pressed.

Source files
------------

// File: rtl/color_scheduler_if.sv
// Button, frame-tick and step-pulse signals exchanged with the colour scheduler.
interface color_scheduler_if;
  logic btn_next;
  logic btn_prev;
  logic btn_auto;
  logic frame_tick;
  logic next;
  logic prev;
  logic auto_on;
  logic pending;

  modport master (
    output btn_next,
    output btn_prev,
    output btn_auto,
    output frame_tick,
    input  next,
    input  prev,
    input  auto_on,
    input  pending
  );

  modport slave (
    input  btn_next,
    input  btn_prev,
    input  btn_auto,
    input  frame_tick,
    output next,
    output prev,
    output auto_on,
    output pending
  );
endinterface

// File: rtl/color_scheduler.sv
// Debounces three push-buttons and turns presses plus an auto-advance timer into
// frame-aligned single-cycle next/prev step pulses.
module color_scheduler #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned AUTO_FRAMES     = 60,
  parameter bit          AUTO_DEFAULT    = 1'b0
) (
  input  logic             CLK50MHZ,
  input  logic             RST,
  color_scheduler_if.slave bus
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax   = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [15:0]     FrameMax = 16'(AUTO_FRAMES - 1);

  localparam int unsigned BtnNext = 0;
  localparam int unsigned BtnPrev = 1;
  localparam int unsigned BtnAuto = 2;

  typedef enum logic [1:0] {
    StIdle,
    StArmed,
    StIssue
  } state_e;

  // Button front end
  logic [2:0]      w_btn_raw;
  logic [2:0]      r_sync1;
  logic [2:0]      r_sync2;
  logic [2:0]      r_level;
  logic [2:0]      r_armed;
  logic [1:0]      r_warm;
  logic [CntW-1:0] r_db_cnt [3];
  logic [2:0]      w_rise;

  assign w_btn_raw = {bus.btn_auto, bus.btn_prev, bus.btn_next};

  always_ff @(posedge CLK50MHZ) begin
    if (RST) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_level <= '0;
      r_armed <= '0;
      r_warm  <= '0;
      for (int i = 0; i < 3; i++) begin
        r_db_cnt[i] <= '0;
      end
    end else begin
      r_sync1 <= w_btn_raw;
      r_sync2 <= r_sync1;
      r_warm  <= {r_warm[0], 1'b1};
      for (int i = 0; i < 3; i++) begin
        if (r_sync2[i] == r_level[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == CntMax) begin
          r_level[i]  <= r_sync2[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + CntW'(1);
        end
        // A button only produces events once it has been seen released after reset,
        // so one held through reset stays silent until it is pressed again.
        if (r_warm[1] && !r_sync2[i] && !r_level[i]) begin
          r_armed[i] <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_rise[i] = r_armed[i] && !r_level[i] && r_sync2[i] && (r_db_cnt[i] == CntMax);
    end
  end

  // Auto-advance timer
  logic        r_auto_on;
  logic [15:0] r_frame_cnt;
  logic        w_auto_due;

  assign w_auto_due = r_auto_on && bus.frame_tick && (r_frame_cnt == FrameMax);

  always_ff @(posedge CLK50MHZ) begin
    if (RST) begin
      r_auto_on   <= AUTO_DEFAULT;
      r_frame_cnt <= '0;
    end else if (w_rise[BtnAuto]) begin
      r_auto_on   <= !r_auto_on;
      r_frame_cnt <= '0;
    end else if (!r_auto_on || w_rise[BtnNext] || w_rise[BtnPrev]) begin
      r_frame_cnt <= '0;
    end else if (bus.frame_tick) begin
      r_frame_cnt <= (r_frame_cnt == FrameMax) ? 16'd0 : r_frame_cnt + 16'd1;
    end
  end

  // Request scheduler
  state_e r_state;
  state_e w_state_d;
  logic   r_pend_next;
  logic   r_pend_prev;
  logic   w_pend_next_d;
  logic   w_pend_prev_d;
  logic   r_next;
  logic   r_prev;
  logic   w_next_d;
  logic   w_prev_d;
  logic   w_decide;
  logic   w_want_next;
  logic   w_want_prev;

  always_comb begin
    w_state_d   = r_state;
    w_next_d    = 1'b0;
    w_prev_d    = 1'b0;
    w_decide    = 1'b0;
    w_want_next = r_pend_next || w_auto_due;
    w_want_prev = r_pend_prev;

    unique case (r_state)
      StIdle:  w_decide = w_auto_due;
      StArmed: w_decide = bus.frame_tick;
      StIssue: w_decide = 1'b0;
      default: w_decide = 1'b0;
    endcase

    // Presses on the deciding edge survive the clear and wait for the next frame.
    w_pend_next_d = (r_pend_next && !w_decide) || w_rise[BtnNext];
    w_pend_prev_d = (r_pend_prev && !w_decide) || w_rise[BtnPrev];

    if (w_decide) begin
      w_state_d = StIssue;
      w_next_d  = w_want_next && !w_want_prev;
      w_prev_d  = w_want_prev && !w_want_next;
    end else if (r_state != StArmed) begin
      w_state_d = (w_pend_next_d || w_pend_prev_d) ? StArmed : StIdle;
    end
  end

  always_ff @(posedge CLK50MHZ) begin
    if (RST) begin
      r_state     <= StIdle;
      r_pend_next <= 1'b0;
      r_pend_prev <= 1'b0;
      r_next      <= 1'b0;
      r_prev      <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_pend_next <= w_pend_next_d;
      r_pend_prev <= w_pend_prev_d;
      r_next      <= w_next_d;
      r_prev      <= w_prev_d;
    end
  end

  assign bus.next    = r_next;
  assign bus.prev    = r_prev;
  assign bus.auto_on = r_auto_on;
  assign bus.pending = r_pend_next || r_pend_prev;

endmodule

// File: tb/tb_color_scheduler.sv
// Bench for color_scheduler: directed vector table, a reset-during-issue sequence,
// then random button/frame traffic against a behavioural model.
module tb_color_scheduler;

  localparam int unsigned Db = 4;
  localparam int unsigned Af = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  color_scheduler_if bus ();

  color_scheduler #(
    .DEBOUNCE_CYCLES(Db),
    .AUTO_FRAMES    (Af),
    .AUTO_DEFAULT   (1'b0)
  ) dut (
    .CLK50MHZ(clk),
    .RST     (rst),
    .bus     (bus)
  );

  always #10 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // in = {rst, next, prev, auto, tick}; exp = {next, prev, pending, auto_on}
  typedef struct {
    int unsigned reps;
    logic [4:0]  in;
    logic [3:0]  exp;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input int unsigned reps, input logic [4:0] in, input logic [3:0] exp);
    vec_t v;
    v.reps = reps;
    v.in   = in;
    v.exp  = exp;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic [4:0] in);
    rst            = in[4];
    bus.btn_next   = in[3];
    bus.btn_prev   = in[2];
    bus.btn_auto   = in[1];
    bus.frame_tick = in[0];
  endtask

  task automatic check(input string tag, input logic [3:0] exp);
    logic [3:0] act;
    act = {bus.next, bus.prev, bus.pending, bus.auto_on};
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: next/prev/pending/auto_on got %b want %b", tag, act, exp);
    end
  endtask

  task automatic step_chk(input string tag, input logic [4:0] in, input logic [3:0] exp);
    drive(in);
    @(posedge clk);
    #1;
    check(tag, exp);
  endtask

  // Behavioural model: synchroniser as a two-deep delay, debouncer as a run length.
  logic [2:0] m_d1, m_d2, m_deb;
  int         m_run [3];
  logic       m_auto, m_pn, m_pp, m_issue, m_on, m_op;
  int         m_fc;

  task automatic model_reset();
    m_d1 = '0; m_d2 = '0; m_deb = '0;
    for (int i = 0; i < 3; i++) m_run[i] = 0;
    m_auto = 1'b0; m_pn = 1'b0; m_pp = 1'b0;
    m_issue = 1'b0; m_on = 1'b0; m_op = 1'b0;
    m_fc = 0;
  endtask

  task automatic model_step(input logic [2:0] btn, input logic tk);
    logic [2:0] press;
    logic       due, dec, wn, wp;
    press = '0;
    for (int i = 0; i < 3; i++) begin
      if (m_d2[i] != m_deb[i]) begin
        m_run[i]++;
        if (m_run[i] == int'(Db)) begin
          m_deb[i] = m_d2[i];
          m_run[i] = 0;
          press[i] = m_d2[i];
        end
      end else begin
        m_run[i] = 0;
      end
    end
    m_d2 = m_d1;
    m_d1 = btn;

    due     = m_auto && tk && (m_fc == int'(Af) - 1);
    dec     = !m_issue && tk && (m_pn || m_pp || due);
    wn      = m_pn || due;
    wp      = m_pp;
    m_on    = dec && wn && !wp;
    m_op    = dec && wp && !wn;
    m_issue = dec;
    if (dec) begin
      m_pn = 1'b0;
      m_pp = 1'b0;
    end
    m_pn = m_pn || press[0];
    m_pp = m_pp || press[1];

    if (press[2]) begin
      m_auto = !m_auto;
      m_fc   = 0;
    end else if (!m_auto || press[0] || press[1]) begin
      m_fc = 0;
    end else if (tk) begin
      m_fc = (m_fc + 1) % int'(Af);
    end
  endtask

  initial begin
    logic [2:0] lv;
    logic       tk;

    // Reset and long single press, issued on the next frame tick
    add(2, 5'b10000, 4'b0000);
    add(4, 5'b00000, 4'b0000);
    add(5, 5'b01000, 4'b0000);
    add(1, 5'b01000, 4'b0010);
    add(4, 5'b01000, 4'b0010);
    add(19, 5'b00000, 4'b0010);
    add(1, 5'b00001, 4'b1000);
    add(8, 5'b00000, 4'b0000);
    // Short glitch is filtered
    add(3, 5'b01000, 4'b0000);
    add(8, 5'b00000, 4'b0000);
    add(1, 5'b00001, 4'b0000);
    add(2, 5'b00000, 4'b0000);
    // Next and prev in the same frame cancel
    add(5, 5'b01100, 4'b0000);
    add(1, 5'b01100, 4'b0010);
    add(10, 5'b00000, 4'b0010);
    add(1, 5'b00001, 4'b0000);
    add(8, 5'b00000, 4'b0000);
    // Prev event on a tick edge waits for the following tick
    add(5, 5'b00100, 4'b0000);
    add(1, 5'b00101, 4'b0010);
    add(3, 5'b00100, 4'b0010);
    add(10, 5'b00000, 4'b0010);
    add(1, 5'b00001, 4'b0100);
    add(8, 5'b00000, 4'b0000);
    // Auto mode: next after every third tick
    add(5, 5'b00010, 4'b0000);
    add(1, 5'b00010, 4'b0001);
    add(10, 5'b00000, 4'b0001);
    for (int t = 1; t <= 7; t++) begin
      add(1, 5'b00001, (t % 3 == 0) ? 4'b1001 : 4'b0001);
      add(2, 5'b00000, 4'b0001);
    end
    // Auto mode with a prev press restarting the interval
    add(2, 5'b10000, 4'b0000);
    add(4, 5'b00000, 4'b0000);
    add(5, 5'b00010, 4'b0000);
    add(1, 5'b00010, 4'b0001);
    add(10, 5'b00000, 4'b0001);
    for (int t = 1; t <= 4; t++) begin
      add(1, 5'b00001, (t == 3) ? 4'b1001 : 4'b0001);
      add(2, 5'b00000, 4'b0001);
    end
    add(5, 5'b00100, 4'b0001);
    add(1, 5'b00100, 4'b0011);
    add(4, 5'b00100, 4'b0011);
    add(8, 5'b00000, 4'b0011);
    add(1, 5'b00001, 4'b0101);
    add(2, 5'b00000, 4'b0001);
    add(1, 5'b00001, 4'b0001);
    add(2, 5'b00000, 4'b0001);
    add(1, 5'b00001, 4'b1001);
    add(2, 5'b00000, 4'b0001);
    add(2, 5'b10000, 4'b0000);
    add(4, 5'b00000, 4'b0000);

    for (int i = 0; i < tbl.size(); i++) begin
      for (int unsigned r = 0; r < tbl[i].reps; r++) begin
        step_chk($sformatf("row%0d", i), tbl[i].in, tbl[i].exp);
      end
    end

    // Reset during an issue cycle with the button held through reset
    for (int i = 0; i < 5; i++) step_chk("f_auto", 5'b00010, 4'b0000);
    step_chk("f_auto_on", 5'b00010, 4'b0001);
    for (int i = 0; i < 10; i++) step_chk("f_auto_rel", 5'b00000, 4'b0001);
    for (int i = 0; i < 5; i++) step_chk("f_press", 5'b01000, 4'b0001);
    step_chk("f_pend", 5'b01000, 4'b0011);
    step_chk("f_issue", 5'b01001, 4'b1001);
    step_chk("f_rst", 5'b11000, 4'b0000);
    for (int i = 0; i < 16; i++) step_chk("f_held", 5'b01000, 4'b0000);
    for (int i = 0; i < 12; i++) step_chk("f_release", 5'b00000, 4'b0000);
    for (int i = 0; i < 5; i++) step_chk("f_repress", 5'b01000, 4'b0000);
    step_chk("f_repend", 5'b01000, 4'b0010);
    step_chk("f_reissue", 5'b00001, 4'b1000);
    step_chk("f_done", 5'b00000, 4'b0000);

    // Random traffic against the model
    drive(5'b10000);
    @(posedge clk);
    @(posedge clk);
    #1;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      drive(5'b00000);
      @(posedge clk);
      model_step(3'b000, 1'b0);
      #1;
    end
    lv = '0;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 9) == 0) lv[0] = ~lv[0];
      if ($urandom_range(0, 9) == 0) lv[1] = ~lv[1];
      if ($urandom_range(0, 29) == 0) lv[2] = ~lv[2];
      tk = ($urandom_range(0, 5) == 0);
      drive({1'b0, lv[0], lv[1], lv[2], tk});
      @(posedge clk);
      model_step(lv, tk);
      #1;
      check($sformatf("rand%0d", c), {m_on, m_op, m_pn || m_pp, m_auto});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
